// File: rtl/dcache_controller_pkg.sv
// rtl/dcache_controller_pkg.sv - shared types and geometry for the L1 data cache controller
package dcache_controller_pkg;

    localparam int NUM_LINES = 32;
    localparam int LINE_BITS = 256;
    localparam int TAG_W     = 22;
    localparam int INDEX_W   = 5;
    localparam int OFFSET_W  = 5;
    localparam int WORD_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_RD   = 2'd2,
        ST_FILL = 2'd3
    } state_e;

    typedef logic [TAG_W-1:0]     tag_t;
    typedef logic [INDEX_W-1:0]   index_t;
    typedef logic [WORD_W-1:0]    word_t;
    typedef logic [LINE_BITS-1:0] line_t;

    typedef struct packed {
        tag_t        tag;
        index_t      index;
        word_t       word;
        logic [1:0]  byte_sel;
    } addr_t;

    function automatic logic [31:0] line_addr(input tag_t tag, input index_t index);
        return {tag, index, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_controller_if.sv
// rtl/dcache_controller_if.sv - line-based data memory bus (enable/write/ack)
interface dcache_controller_if;
    import dcache_controller_pkg::*;

    logic        mem_enable;
    logic        mem_write;
    logic [31:0] mem_addr;
    line_t       mem_wdata;
    line_t       mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_enable,
        output mem_write,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_enable,
        input  mem_write,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/dcache_sram.sv
// rtl/dcache_sram.sv - tag/valid/dirty/data arrays with one index port
module dcache_sram
    import dcache_controller_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  index_t      index_i,
    input  logic        word_we_i,
    input  word_t       word_sel_i,
    input  logic [31:0] word_data_i,
    input  logic        line_we_i,
    input  tag_t        line_tag_i,
    input  line_t       line_data_i,
    output logic        valid_o,
    output logic        dirty_o,
    output tag_t        tag_o,
    output line_t       line_o
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    tag_t                 tag_q  [NUM_LINES];
    line_t                data_q [NUM_LINES];

    // Only the status bits are cleared; tag/data are don't-care while invalid.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we_i) begin
            valid_q[index_i] <= 1'b1;
            dirty_q[index_i] <= 1'b0;
        end else if (word_we_i) begin
            dirty_q[index_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (line_we_i) begin
            tag_q[index_i]  <= line_tag_i;
            data_q[index_i] <= line_data_i;
        end else if (word_we_i) begin
            data_q[index_i][{word_sel_i, 5'b0} +: 32] <= word_data_i;
        end
    end

    assign valid_o = valid_q[index_i];
    assign dirty_o = dirty_q[index_i];
    assign tag_o   = tag_q[index_i];
    assign line_o  = data_q[index_i];

endmodule

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-back write-allocate L1 data cache controller
module dcache_controller
    import dcache_controller_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cpu_req_i,
    input  logic        cpu_write_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    output logic        cpu_stall_o,
    dcache_controller_if.master mem
);

    addr_t       cpu_addr;
    state_e      state_q;
    logic        mem_enable_q;
    logic        mem_write_q;
    logic [31:0] mem_addr_q;
    line_t       mem_data_q;

    logic        line_valid;
    logic        line_dirty;
    tag_t        line_tag;
    line_t       line_data;
    logic        hit;
    logic        in_idle;
    logic        word_we;
    logic        line_we;
    logic        unused_byte_sel;

    assign cpu_addr        = cpu_addr_i;
    assign unused_byte_sel = ^cpu_addr.byte_sel;

    assign in_idle = (state_q == ST_IDLE);
    assign hit     = line_valid && (line_tag == cpu_addr.tag);
    assign word_we = rst_i && in_idle && cpu_req_i && cpu_write_i && hit;
    assign line_we = rst_i && (state_q == ST_FILL);

    dcache_sram u_sram (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .index_i     (cpu_addr.index),
        .word_we_i   (word_we),
        .word_sel_i  (cpu_addr.word),
        .word_data_i (cpu_data_i),
        .line_we_i   (line_we),
        .line_tag_i  (cpu_addr.tag),
        .line_data_i (mem.mem_rdata),
        .valid_o     (line_valid),
        .dirty_o     (line_dirty),
        .tag_o       (line_tag),
        .line_o      (line_data)
    );

    assign cpu_data_o  = (in_idle && hit) ? line_data[{cpu_addr.word, 5'b0} +: 32] : 32'd0;
    assign cpu_stall_o = !in_idle || (cpu_req_i && !hit);

    // Bus outputs are registered on each transition so they stay put until ack.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cpu_req_i && !hit) begin
                        mem_enable_q <= 1'b1;
                        if (line_valid && line_dirty) begin
                            state_q     <= ST_WB;
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= line_addr(line_tag, cpu_addr.index);
                            mem_data_q  <= line_data;
                        end else begin
                            state_q     <= ST_RD;
                            mem_write_q <= 1'b0;
                            mem_addr_q  <= line_addr(cpu_addr.tag, cpu_addr.index);
                            mem_data_q  <= '0;
                        end
                    end
                end
                ST_WB: begin
                    // Enable stays high; the falling write strobe starts the refill.
                    if (mem.mem_ack) begin
                        state_q     <= ST_RD;
                        mem_write_q <= 1'b0;
                        mem_addr_q  <= line_addr(cpu_addr.tag, cpu_addr.index);
                        mem_data_q  <= '0;
                    end
                end
                ST_RD: begin
                    if (mem.mem_ack) begin
                        state_q      <= ST_FILL;
                        mem_enable_q <= 1'b0;
                        mem_addr_q   <= '0;
                    end
                end
                ST_FILL: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    mem_enable_q <= 1'b0;
                    mem_write_q  <= 1'b0;
                    mem_addr_q   <= '0;
                    mem_data_q   <= '0;
                end
            endcase
        end
    end

    assign mem.mem_enable = mem_enable_q;
    assign mem.mem_write  = mem_write_q;
    assign mem.mem_addr   = mem_addr_q;
    assign mem.mem_wdata  = mem_data_q;

endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - randomized self-checking bench with a behavioural cache/memory model
module tb_dcache_controller;
    import dcache_controller_pkg::*;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        line_t       data;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_write;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    bit          started = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    dcache_controller_if mif();

    dcache_controller dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .cpu_req_i   (cpu_req),
        .cpu_write_i (cpu_write),
        .cpu_addr_i  (cpu_addr),
        .cpu_data_i  (cpu_wdata),
        .cpu_data_o  (cpu_rdata),
        .cpu_stall_o (cpu_stall),
        .mem         (mif)
    );

    always #5 clk = ~clk;

    // Reference state: per-line tag/valid/dirty and the program-order value of every word.
    bit          m_valid [NUM_LINES];
    bit          m_dirty [NUM_LINES];
    tag_t        m_tag   [NUM_LINES];
    logic [31:0] ref_word [int unsigned];
    logic [31:0] exp_rdata;
    txn_t        obs_q[$];
    txn_t        exp_q[$];

    line_t       mem_arr [128];
    bit          m_busy;
    bit          m_wr;
    int          m_cnt;
    logic [31:0] m_addr;
    line_t       m_wdata;

    function automatic void check(input bit ok, input string name, input line_t act, input line_t exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        logic [31:0] wa;
        line_t       l;
        int          w;
        wa = a & ~32'h3;
        if (ref_word.exists(wa)) return ref_word[wa];
        l = mem_arr[wa[11:5]];
        w = int'(wa[4:2]);
        return l[w*32 +: 32];
    endfunction

    // Memory: samples enable while idle, 8 wait cycles, one-cycle ack, data the cycle after ack.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy      <= 1'b0;
            mif.mem_ack <= 1'b0;
        end else if (mif.mem_ack) begin
            mif.mem_ack <= 1'b0;
            if (m_wr) mem_arr[m_addr[11:5]] <= m_wdata;
            else      mif.mem_rdata <= mem_arr[m_addr[11:5]];
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_busy      <= 1'b0;
                mif.mem_ack <= 1'b1;
            end
            m_cnt <= m_cnt - 1;
        end else if (mif.mem_enable === 1'b1) begin
            m_busy  <= 1'b1;
            m_cnt   <= 7;
            m_addr  <= mif.mem_addr;
            m_wr    <= mif.mem_write;
            m_wdata <= mif.mem_wdata;
            obs_q.push_back('{mif.mem_write, mif.mem_addr, mif.mem_wdata});
        end
    end

    always @(negedge clk) begin
        if (started && rst_n) begin
            if (cpu_req && !cpu_stall && !cpu_write)
                check(cpu_rdata == exp_rdata, "load_data", cpu_rdata, exp_rdata);
            if (!mif.mem_enable) begin
                check(!mif.mem_write && mif.mem_addr == 0 && mif.mem_wdata == '0,
                      "idle_bus_zero", {mif.mem_write, mif.mem_addr}, '0);
            end else begin
                check(mif.mem_addr[4:0] == 5'd0, "bus_addr_aligned", mif.mem_addr, mif.mem_addr & ~32'h1F);
                if (m_busy || mif.mem_ack)
                    check(mif.mem_write == m_wr && mif.mem_addr == m_addr && mif.mem_wdata == m_wdata,
                          "bus_stable", mif.mem_addr, m_addr);
            end
        end
    end

    task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          output int stalls, output logic [31:0] rd);
        int          idx;
        tag_t        tg;
        bit          hit;
        int          exp_stall;
        line_t       vl;
        logic [31:0] vla;
        idx = int'(a[9:5]);
        tg  = a[31:10];
        hit = m_valid[idx] && (m_tag[idx] == tg);
        exp_q.delete();
        if (!hit) begin
            if (m_dirty[idx]) begin
                vla = {m_tag[idx], a[9:5], 5'b0};
                for (int w = 0; w < 8; w++) vl[w*32 +: 32] = ref_read(vla + 32'(4*w));
                exp_q.push_back('{1'b1, vla, vl});
            end
            exp_q.push_back('{1'b0, {a[31:5], 5'b0}, '0});
        end
        exp_stall = hit ? 0 : (m_dirty[idx] ? 20 : 11);
        obs_q.delete();
        cpu_req   = 1'b1;
        cpu_write = wr;
        cpu_addr  = a;
        cpu_wdata = d;
        exp_rdata = ref_read(a);
        stalls    = 0;
        @(negedge clk);
        while (cpu_stall && stalls < 100) begin
            stalls++;
            @(negedge clk);
        end
        rd = cpu_rdata;
        check(stalls == exp_stall, "stall_cycles", stalls, exp_stall);
        @(posedge clk);
        #1;
        check(obs_q.size() == exp_q.size(), "txn_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check(obs_q[i].wr == exp_q[i].wr && obs_q[i].addr == exp_q[i].addr &&
                  obs_q[i].data == exp_q[i].data, "txn", obs_q[i].addr, exp_q[i].addr);
        end
        if (!hit) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_dirty[idx] = 1'b0;
        end
        if (wr) begin
            m_dirty[idx] = 1'b1;
            ref_word[a & ~32'h3] = d;
        end
    endtask

    task automatic reset_during_wb(input logic [31:0] a);
        int          idx;
        int          stalls;
        logic [31:0] rd;
        logic [31:0] la;
        idx = int'(a[9:5]);
        check(m_dirty[idx] && m_tag[idx] != a[31:10], "rst_setup_dirty_victim", m_dirty[idx], 1'b1);
        cpu_req   = 1'b1;
        cpu_write = 1'b0;
        cpu_addr  = a;
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        check(mif.mem_enable && mif.mem_write, "wb_active_cycle5", {mif.mem_enable, mif.mem_write}, 2'b11);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (m_dirty[i]) begin
                la = {m_tag[i], 5'(i), 5'b0};
                for (int w = 0; w < 8; w++) ref_word.delete(la + 32'(4*w));
            end
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        #1;
        check(mif.mem_enable == 1'b0, "rst_mem_enable", mif.mem_enable, 1'b0);
        check(cpu_stall == 1'b1, "rst_stall_invalid", cpu_stall, 1'b1);
        access(1'b0, a, 32'd0, stalls, rd);
        check(stalls == 11, "rst_reload_clean_miss", stalls, 11);
    endtask

    initial begin
        int          stalls;
        logic [31:0] rd;
        logic [31:0] a;
        for (int i = 0; i < 128; i++)
            for (int w = 0; w < 8; w++)
                mem_arr[i][w*32 +: 32] = init_word(32'(i*32 + w*4));
        for (int i = 0; i < NUM_LINES; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
        end
        rst_n     = 1'b0;
        cpu_req   = 1'b0;
        cpu_write = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        exp_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        started = 1'b1;
        #1;
        check(cpu_stall == 1'b0, "reset_stall_noreq", cpu_stall, 1'b0);
        check(mif.mem_enable == 1'b0, "reset_mem_enable", mif.mem_enable, 1'b0);
        check(cpu_rdata == 32'd0, "reset_cpu_data", cpu_rdata, 32'd0);
        cpu_req  = 1'b1;
        cpu_addr = 32'h40;
        #1;
        check(cpu_stall == 1'b1, "reset_stall_follows_req", cpu_stall, 1'b1);

        access(1'b0, 32'h40, 32'd0, stalls, rd);
        check(stalls == 11, "clean_miss_stall", stalls, 11);
        check(rd == 32'hDEADBEEF, "clean_miss_data", rd, 32'hDEADBEEF);
        access(1'b1, 32'h44, 32'h12345678, stalls, rd);
        check(stalls == 0, "store_hit_stall", stalls, 0);
        access(1'b0, 32'h44, 32'd0, stalls, rd);
        check(rd == 32'h12345678, "store_then_load", rd, 32'h12345678);
        access(1'b0, 32'h440, 32'd0, stalls, rd);
        check(stalls == 20, "dirty_miss_stall", stalls, 20);
        check(mem_arr[2][63:32] == 32'h12345678, "writeback_word1", mem_arr[2][63:32], 32'h12345678);
        access(1'b1, 32'h80, 32'hCAFEF00D, stalls, rd);
        check(stalls == 11, "store_miss_stall", stalls, 11);
        access(1'b0, 32'h80, 32'd0, stalls, rd);
        check(rd == 32'hCAFEF00D, "store_miss_data", rd, 32'hCAFEF00D);
        for (int w = 0; w < 8; w++) begin
            access(1'b0, 32'h440 + 32'(4*w), 32'd0, stalls, rd);
            check(stalls == 0, "b2b_hit_stall", stalls, 0);
        end

        reset_during_wb(32'h480);
        access(1'b0, 32'h80, 32'd0, stalls, rd);
        check(rd == init_word(32'h80), "lost_store_after_reset", rd, init_word(32'h80));

        for (int n = 0; n < 300; n++) begin
            a = (32'($urandom_range(0, 3)) << 10) | ($urandom & 32'h3FF);
            access(1'($urandom_range(0, 1)), a, $urandom, stalls, rd);
            if ($urandom_range(0, 3) == 0) begin
                cpu_req = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        cpu_req = 1'b0;
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate L1 data cache controller that sits between the CPU load/store stage and the 256-bit line-based data memory. It is the initiator on the data memory's enable/write/ack protocol: it serves CPU word accesses from 32 on-chip lines and issues line-sized write-back and refill transactions to memory on misses. It stalls the CPU while a miss is outstanding.

## Interface
- NUM_LINES, 32, cache lines; index width log2(NUM_LINES)=5
- LINE_BITS, 256, line width; equals the memory data width
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  synchronous, active-low reset
- cpu_req_i  in  1  CPU access valid this cycle
- cpu_write_i  in  1  1=store, 0=load
- cpu_addr_i  in  32  byte address; bits [1:0] ignored
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data, valid when cpu_req_i & ~cpu_stall_o
- cpu_stall_o  out  1  CPU must hold its request stable while high
- mem_enable_o  out  1  memory transaction request
- mem_write_o  out  1  1=write-back, 0=refill
- mem_addr_o  out  32  line-aligned byte address, bits [4:0]=0
- mem_data_o  out  256  write-back line data
- mem_data_i  in  256  refill line data
- mem_ack_i  in  1  single-cycle transaction-complete pulse

## Operation
- Address split: tag=[31:10] (22 b), index=[9:5], word=[4:2]; word w occupies line bits [32w+31:32w].
- Per line: valid, dirty, tag, 256-bit data; all valid/dirty cleared by reset; data/tag not reset.
- Hit = valid[index] & tag match; combinational in IDLE.
- States: IDLE, WB, RD, FILL.
- IDLE: no req -> stay. Load hit -> cpu_data_o = selected word, no stall. Store hit -> word written, dirty set at clock edge. Miss & victim dirty -> WB. Miss & clean/invalid -> RD.
- WB: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag,index,5'b0}, mem_data_o=victim line; on mem_ack_i -> RD.
- RD: mem_enable_o=1, mem_write_o=0, mem_addr_o={cpu tag,index,5'b0}; on mem_ack_i -> FILL.
- FILL: line <= mem_data_i, tag <= cpu tag, valid=1, dirty=0; -> IDLE, where the access re-evaluates as a hit (store miss completes there, setting dirty).
- cpu_stall_o = (state!=IDLE) | (cpu_req_i & ~hit).
- Outside WB/RD: mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0.
- Reset in any state: next cycle IDLE, all mem outputs 0, cpu_stall_o follows IDLE rule with all lines invalid; any in-flight transaction is abandoned (memory is reset by the same rst_i).

## Timing
- Reset values: mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, cpu_data_o=0 when no hit, cpu_stall_o=cpu_req_i.
- Memory protocol: memory samples enable at an edge while idle, counts 8 wait cycles, raises mem_ack_i for one cycle; read data on mem_data_i is valid from the cycle after ack, hence the dedicated FILL state.
- mem_enable_o must be low in the cycle after ack of a lone transaction; WB->RD back-to-back keeps enable high with mem_write_o dropping, which the memory latches as a new read.
- Write-back and refill signals held stable from request until ack.
- Clean miss (miss in cycle 0): RD cycles 1-9, ack in cycle 9, FILL cycle 10, hit in cycle 11; cpu_stall_o high cycles 0-10 (11 cycles).
- Dirty miss: WB 1-9, RD 10-18, FILL 19, hit cycle 20; stall 20 cycles.
- Hit: zero stall; load data combinational same cycle.
- mem_ack_i outside WB/RD: ignored.

## Structure
- Shared package: state encoding (IDLE, WB, RD, FILL), TAG_W=22, INDEX_W=5, OFFSET_W=5, LINE_BITS.
- One sub-module: dcache_sram (tag/valid/dirty/data arrays, one index port, word-write and full-line-write enables, synchronous active-low clear of valid/dirty). Controller FSM and hit logic stay in dcache_controller.

## Test plan
- After reset, load 0x0000_0040 -> stall 11 cycles, one read at mem_addr_o=0x40; memory word 0 = 0xDEADBEEF returned, stall drops.
- Store 0x12345678 to 0x44 after that fill -> no stall, no mem transaction; subsequent load 0x44 returns 0x12345678.
- Load 0x0000_0440 (same index 2, new tag) -> write-back of dirty line to 0x40 then refill from 0x440; stall exactly 20 cycles; memory at 0x40 word 1 = 0x12345678.
- Store miss to 0x80 on invalid line -> refill then word written, dirty set; no extra write-back.
- Assert rst_i=0 during WB cycle 5 -> next cycle IDLE, mem_enable_o=0, all lines invalid; reload misses.
- Back-to-back hits on 8 words of one line -> cpu_stall_o never asserted, mem_enable_o stays 0.
